// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
package alu_pkg;

    localparam int SHAMT_W = 5;

    // Operation codes as produced by the ALU control decoder.
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_AND = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SRA = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_NE  = 4'b1010,
        ALU_LT  = 4'b1011,
        ALU_GE  = 4'b1100,
        ALU_EQ  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    // True for the three ops handled by the iterative shifter.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SRA) || (op == ALU_SRL) || (op == ALU_SLL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU datapath: every non-shift result plus the shift-by-0
// passthrough. Undefined op codes yield zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    lt;

    assign a_s = a;
    assign b_s = b;
    assign lt  = (a_s < b_s);

    // Select the result for the current op; branch ops return a 1-bit condition.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_XOR: result = a ^ b;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            ALU_SRA: result = a;
            ALU_SRL: result = a;
            ALU_SLL: result = a;
            ALU_NE:  result = {{(WIDTH-1){1'b0}}, (a != b)};
            ALU_LT:  result = {{(WIDTH-1){1'b0}}, lt};
            ALU_GE:  result = {{(WIDTH-1){1'b0}}, ~lt};
            ALU_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshake. Non-shift ops finish in one
// cycle; shifts step one bit per cycle and hold off new work via in_ready.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             busy
);

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(1);

    alu_state_t         state;
    alu_state_t         state_next;
    logic [WIDTH-1:0]   core_result;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]   result_q;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic [3:0]         op_q;
    logic               accept;
    logic               start_shift;

    // One-bit shift step used by the iterative shifter.
    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (op)
            ALU_SLL: r = {v[WIDTH-2:0], 1'b0};
            ALU_SRL: r = {1'b0, v[WIDTH-1:1]};
            default: r = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign shamt    = SrcB[SHAMT_W-1:0];
    assign acc_step = shift_one(op_q, acc);

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (Operation),
        .a      (SrcA),
        .b      (SrcB),
        .result (core_result)
    );

    // Next-state and handshake outputs; all outputs decode from state only.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        start_shift = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (is_shift(Operation) && (shamt != '0)) begin
                        start_shift = 1'b1;
                        state_next  = SHIFT;
                    end else begin
                        state_next  = DONE;
                    end
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Accumulator, counter, latched op and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q <= Operation;
            if (start_shift) begin
                acc <= SrcA;
                cnt <= shamt;
            end else begin
                result_q <= core_result;
            end
        end else if (state == SHIFT) begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
            // Final step: publish the shifted value in the same cycle.
            if (cnt == CNT_LAST) result_q <= acc_step;
        end
    end

    assign ALUResult = result_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, random ops against
// an arithmetic reference model, backpressure and reset-abort sequences.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[15];

    alu_multicycle #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference result straight from the op-code definitions.
    function automatic logic [31:0] ref_result(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        int sh;
        logic lt;
        sh = int'(b[4:0]);
        lt = ($signed(a) < $signed(b));
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a ^ b;
            4'd3:  return a | b;
            4'd4:  return a & b;
            4'd5:  return {31'b0, lt};
            4'd6:  return $signed(a) >>> sh;
            4'd7:  return a >> sh;
            4'd8:  return a << sh;
            4'd10: return {31'b0, a != b};
            4'd11: return {31'b0, lt};
            4'd12: return {31'b0, !lt};
            4'd13: return {31'b0, a == b};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'd6 || op == 4'd7 || op == 4'd8) && b[4:0] != 5'd0)
            return 1 + int'(b[4:0]);
        return 1;
    endfunction

    // Issue one op and wait (bounded) for its result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit hs_ok);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        SrcA      = $urandom;
        SrcB      = $urandom;
        Operation = 4'($urandom);
        lat   = 1;
        hs_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready || !busy) hs_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready || !busy) hs_ok = 1'b0;
        res = ALUResult;
    endtask

    // Issue, compare result/latency/handshake, then let the result drain.
    task automatic run_check(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          hs_ok;
        do_op(op, a, b, res, lat, hs_ok);
        check({name, " result"}, res, exp_res);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " handshake"}, {31'b0, hs_ok}, 32'd1);
        @(posedge clk); #1;
        check({name, " drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        bit          hs_ok;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1};
        tbl[1]  = '{4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1};
        tbl[2]  = '{4'b0110, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32};
        tbl[3]  = '{4'b0111, 32'h80000000, 32'd31,       32'h00000001, 32};
        tbl[4]  = '{4'b1000, 32'h00000001, 32'h00000020, 32'h00000001, 1};
        tbl[5]  = '{4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
        tbl[6]  = '{4'b1100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
        tbl[7]  = '{4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
        tbl[8]  = '{4'b1101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
        tbl[9]  = '{4'b1101, 32'h00000005, 32'h00000005, 32'h00000001, 1};
        tbl[10] = '{4'b0101, 32'h00000005, 32'h00000005, 32'h00000000, 1};
        tbl[11] = '{4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1};
        tbl[12] = '{4'b1000, 32'h00000003, 32'h00000004, 32'h00000030, 5};
        tbl[13] = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
        tbl[14] = '{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Operation = 4'h0;
        SrcA      = '0;
        SrcB      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset ALUResult", ALUResult, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++)
            run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

        // Backpressure: result held while out_ready is low, new requests ignored.
        out_ready = 1'b0;
        do_op(4'b0010, 32'hF0F0F0F0, 32'hFFFF0000, res, lat, hs_ok);
        check("bp result", res, 32'h0F0FF0F0);
        check("bp latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            Operation = 4'b0000;
            SrcA      = $urandom;
            SrcB      = $urandom;
            @(posedge clk); #1;
            check("bp hold valid", {31'b0, out_valid}, 32'd1);
            check("bp hold result", ALUResult, 32'h0F0FF0F0);
            check("bp hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release valid", {31'b0, out_valid}, 32'd0);
        check("bp release in_ready", {31'b0, in_ready}, 32'd1);
        check("bp keeps result", ALUResult, 32'h0F0FF0F0);
        run_check("bp next", 4'b0001, 32'd10, 32'd3, 32'd7, 1);

        // Reset in the middle of a shift by 10.
        Operation = 4'b1000;
        SrcA      = 32'hDEADBEEF;
        SrcB      = 32'd10;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort busy before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        check("abort ALUResult", ALUResult, 32'h0);
        check("abort in_ready", {31'b0, in_ready}, 32'd1);
        check("abort busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_check("after abort add", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 0) a = {a[31], 31'($urandom)} | 32'h80000000;
            run_check($sformatf("rand%0d op%0d", i, op), op, a, b,
                      ref_result(op, a, b), ref_latency(op, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execute-stage ALU consuming the 4-bit `Operation` code produced by the ALU control decoder together with both operands. It returns a 32-bit result through a valid/ready handshake. Logic, arithmetic, compare and branch-condition ops complete in one cycle. Shifts use an iterative one-bit-per-cycle shifter, so the block stalls the pipeline through backpressure rather than through a wide barrel shifter.

## Interface
- `WIDTH`, 32, operand and result width; only 32 is supported.
- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and `Operation` are valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `Operation`  in  4  op code, encoded as listed under Operation.
- `SrcA`  in  32  operand A (rs1).
- `SrcB`  in  32  operand B (rs2 or immediate); shift amount is `SrcB[4:0]`.
- `out_valid`  out  1  `ALUResult` is valid.
- `out_ready`  in  1  consumer takes the result.
- `ALUResult`  out  32  result; branch ops return `{31'b0, cond}`.
- `busy`  out  1  high in SHIFT or DONE.

## Operation
- Op codes:
  - 0000 ADD (add, addi, lw/sw address)
  - 0001 SUB
  - 0010 XOR
  - 0011 OR
  - 0100 AND
  - 0101 SLT (signed)
  - 0110 SRA
  - 0111 SRL
  - 1000 SLL
  - 1010 NE
  - 1011 LT (signed)
  - 1100 GE (signed)
  - 1101 EQ
  - 1001, 1110, 1111: result 0, treated as single-cycle.
- Arithmetic:
  - ADD and SUB wrap modulo 2^32 with no overflow flag.
  - SLT, LT and GE compare `$signed(SrcA)` against `$signed(SrcB)`.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `in_ready=1`. On `in_valid`, latch the op.
    - Non-shift op, or shift with `SrcB[4:0]==0`: compute the result (shift with amount 0 returns SrcA) into the result register, then go to DONE.
    - Shift op with amount k>0: load the accumulator with SrcA and the counter with k, then go to SHIFT.
  - SHIFT: each cycle, shift the accumulator by 1 (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and decrement the counter. On the cycle the counter reaches 0, copy the accumulator into the result register and go to DONE.
  - DONE: `out_valid=1`; `ALUResult` is held stable. On `out_ready`, go to IDLE.
- Inputs are ignored outside IDLE. `in_valid` may drop at any time without effect.

## Timing
- Reset values:
  - state IDLE
  - `in_ready=1`
  - `out_valid=0`
  - `busy=0`
  - `ALUResult=0`
  - accumulator 0, counter 0
- Reset asserted mid-shift or mid-DONE aborts the operation immediately. The result is discarded and `out_valid` falls asynchronously.
- Latency, counted from the accepting edge to `out_valid` high:
  - non-shift op, or shift by 0: 1 cycle
  - shift by k: 1+k cycles; maximum 32, for k=31.
- `in_ready` is combinational from state, so `in_ready = (state==IDLE)`.
- No result-to-accept bypass exists: the DONE&`out_ready` edge returns to IDLE, and the next accept happens at the earliest 1 cycle later.
- Peak throughput is one op per 2 cycles.
- `out_valid` never drops without `out_ready`. `ALUResult` does not change while `out_valid=1`.
- `ALUResult` keeps its last value in IDLE; only reset clears it.

## Structure
- Shared package `alu_pkg` holds:
  - `typedef enum logic [3:0] alu_op_t` with the op codes above; the decoder is retyped to use it.
  - `typedef enum logic [1:0] alu_state_t` (IDLE, SHIFT, DONE).
  - `localparam SHAMT_W = 5`.
- One combinational sub-module, `alu_core`, computes every non-shift result, including the shift-by-0 passthrough. `alu_multicycle` instantiates it and owns the FSM, the shifter, the counter and the handshake.

## Test plan
- ADD, A=0x7FFFFFFF, B=1, out_ready=1 → `out_valid` 1 cycle after accept, result 0x80000000. SUB, A=0, B=1 → 0xFFFFFFFF.
- SRA, A=0x80000000, B=31 → `in_ready` low for the whole operation, `out_valid` 32 cycles after accept, result 0xFFFFFFFF. SRL with the same operands → 0x00000001. SLL, A=1, B=0x20 (shamt 0) → result 1 after 1 cycle.
- Branch ops with A=-1 (0xFFFFFFFF), B=1 → LT=1, GE=0, NE=1, EQ=0. With A=B=5 → EQ=1, SLT=0.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR 0xF0F0F0F0 ^ 0xFFFF0000 → result 0x0F0FF0F0 stays stable, `out_valid` stays high, `in_valid` pulses are ignored; accept resumes 1 cycle after out_ready=1.
- Reset asserted 3 cycles into an SLL by 10 → `out_valid`=0, `ALUResult`=0, state IDLE. After release, ADD 2+3 → 5 with no residue from the aborted shift.
- Undefined code 1110 with any operands → result 0, latency 1.
